// File: rtl/wb_dbg_master_pkg.sv
// Shared constants for the serial-command Wishbone debug initiator: command/response bytes,
// FSM state encoding and bus widths.
package wb_dbg_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h2E;
  localparam logic [7:0] RSP_ERR   = 8'h21;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_BUS  = 3'd3;
  localparam logic [2:0] ST_SEND = 3'd4;

endpackage

// File: rtl/wb_dbg_master_if.sv
// Wishbone initiator-side signal bundle; master modport faces the debug FSM,
// slave modport faces the interconnect port.
interface wb_dbg_master_if
  import wb_dbg_pkg::*;
();

  logic [ADR_W-1:0] wb_adr_o;
  logic [DAT_W-1:0] wb_dat_o;
  logic [DAT_W-1:0] wb_dat_i;
  logic [SEL_W-1:0] wb_sel_o;
  logic             wb_we_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic             wb_ack_i;
  logic             wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/wb_dbg_master.sv
// Byte-stream to single 32-bit Wishbone read/write bridge with byte responses.
// Optional bus-ack timeout enabled by defining WB_DBG_TIMEOUT_EN.
module wb_dbg_master
  import wb_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  wb_dbg_master_if.master wb,
  output logic       busy
);

  logic [2:0]       state_q, state_n;
  logic [1:0]       cnt_q, cnt_n;
  logic             we_q, we_n;
  logic [ADR_W-1:0] adr_q, adr_n;
  logic [DAT_W-1:0] dat_q, dat_n;
  logic [DAT_W-1:0] rd_q, rd_n;
  logic             err_q, err_n;
  logic             cyc_q, cyc_n;
  logic [SEL_W-1:0] sel_q;
  logic [7:0]       tx_data_q, tx_data_n;
  logic             tx_valid_q, tx_valid_n;
  logic             busy_q;
  logic             tmo_hit;

`ifdef WB_DBG_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;

  // Counts cycles spent in BUS; held at zero everywhere else so each cycle starts fresh.
  always_ff @(posedge clk) begin
    if (reset || state_q != ST_BUS) tmo_q <= '0;
    else                            tmo_q <= tmo_q + TMO_W'(1);
  end

  assign tmo_hit = (state_q == ST_BUS) && (tmo_q == TMO_W'(TIMEOUT - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      cyc_q      <= 1'b0;
      sel_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      we_q       <= we_n;
      adr_q      <= adr_n;
      dat_q      <= dat_n;
      rd_q       <= rd_n;
      err_q      <= err_n;
      cyc_q      <= cyc_n;
      sel_q      <= {SEL_W{cyc_n}};
      tx_data_q  <= tx_data_n;
      tx_valid_q <= tx_valid_n;
      busy_q     <= (state_n != ST_IDLE);
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    we_n       = we_q;
    adr_n      = adr_q;
    dat_n      = dat_q;
    rd_n       = rd_q;
    err_n      = err_q;
    cyc_n      = cyc_q;
    tx_data_n  = tx_data_q;
    tx_valid_n = tx_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
          we_n    = (rx_data == CMD_WRITE);
          cnt_n   = '0;
          state_n = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          adr_n = {adr_q[ADR_W-9:0], rx_data};
          cnt_n = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (we_q) begin
              state_n = ST_DATA;
            end else begin
              state_n = ST_BUS;
              cyc_n   = 1'b1;
            end
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          dat_n = {dat_q[DAT_W-9:0], rx_data};
          cnt_n = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_n = ST_BUS;
            cyc_n   = 1'b1;
          end
        end
      end
      ST_BUS: begin
        if (wb.wb_ack_i || wb.wb_err_i) begin
          cyc_n   = 1'b0;
          err_n   = wb.wb_err_i;
          state_n = ST_SEND;
          if (!we_q && !wb.wb_err_i) rd_n = wb.wb_dat_i;
        end else if (tmo_hit) begin
          cyc_n   = 1'b0;
          err_n   = 1'b1;
          state_n = ST_SEND;
        end
      end
      ST_SEND: begin
        // First SEND cycle loads the response; rd_q shifts so its top byte is always on the wire.
        if (!tx_valid_q) begin
          tx_valid_n = 1'b1;
          cnt_n      = '0;
          tx_data_n  = err_q ? RSP_ERR : (we_q ? RSP_OK : rd_q[31:24]);
        end else if (tx_ready) begin
          if (err_q || we_q || cnt_q == 2'd3) begin
            tx_valid_n = 1'b0;
            state_n    = ST_IDLE;
          end else begin
            cnt_n     = cnt_q + 2'd1;
            tx_data_n = rd_q[23:16];
            rd_n      = {rd_q[23:0], 8'h00};
          end
        end
      end
      default: begin
        state_n    = ST_IDLE;
        cyc_n      = 1'b0;
        tx_valid_n = 1'b0;
      end
    endcase
  end

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_wb_dbg_master.sv
// Self-checking bench for wb_dbg_master: directed vector table, hand-written corner sequences
// and randomized commands checked against a command-level response model.
module tb_wb_dbg_master;

  localparam int unsigned TMO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  wb_dbg_master_if bus ();

  wb_dbg_master #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .wb       (bus),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Slave behaviour knobs, written only by the main sequence.
  int          slv_delay = 0;
  bit          slv_err   = 1'b0;
  bit          slv_noack = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          ready_mode = 0;  // 0 always ready, 1 held low, 2 random

  int wcnt = 0;
  initial begin
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.wb_cyc_o && !bus.wb_ack_i && !bus.wb_err_i && !slv_noack) begin
        if (wcnt >= slv_delay) begin
          if (slv_err) bus.wb_err_i = 1'b1;
          else begin
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = slv_rdata;
          end
          wcnt = 0;
        end else wcnt++;
      end else begin
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_dat_i = $urandom;
        if (!bus.wb_cyc_o) wcnt = 0;
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'b0;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Bus monitor and tx collector; counters only ever grow, the main sequence uses baselines.
  logic [7:0]  got_tx[$];
  int          txn_cnt  = 0;
  int          stab_err = 0;
  bit          in_cyc   = 1'b0;
  logic [31:0] m_adr, m_dat;
  logic        m_we;
  logic [3:0]  m_sel;
  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) got_tx.push_back(tx_data);
      if (bus.wb_stb_o !== bus.wb_cyc_o) stab_err++;
      if (bus.wb_cyc_o) begin
        if (!in_cyc) begin
          txn_cnt++;
          m_adr = bus.wb_adr_o;
          m_dat = bus.wb_dat_o;
          m_we  = bus.wb_we_o;
          m_sel = bus.wb_sel_o;
        end else if (bus.wb_adr_o !== m_adr || bus.wb_dat_o !== m_dat ||
                     bus.wb_we_o !== m_we || bus.wb_sel_o !== 4'hF) begin
          stab_err++;
        end
        in_cyc = 1'b1;
      end else in_cyc = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  logic [7:0] cmd_q[$];

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic build_cmd(input bit wr, input logic [31:0] adr, input logic [31:0] dat,
                           input bit has_junk, input logic [7:0] junk);
    cmd_q.delete();
    if (has_junk) cmd_q.push_back(junk);
    cmd_q.push_back(wr ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) cmd_q.push_back(adr[8*i +: 8]);
    if (wr) for (int i = 3; i >= 0; i--) cmd_q.push_back(dat[8*i +: 8]);
  endtask

  // Response model: what the host should see for one command, from the protocol rules alone.
  task automatic model_rsp(input bit wr, input bit err, input logic [31:0] rdata,
                           output int n, output logic [31:0] bytes);
    if (err)     begin n = 1; bytes = {8'h21, 24'h0}; end
    else if (wr) begin n = 1; bytes = {8'h2E, 24'h0}; end
    else         begin n = 4; bytes = rdata;          end
  endtask

  task automatic run_cmd(input string tag, input int exp_n, input logic [31:0] exp_bytes,
                         input bit wr, input logic [31:0] adr, input logic [31:0] dat);
    int  base_tx, base_txn, base_stab;
    bit  done;
    base_tx   = got_tx.size();
    base_txn  = txn_cnt;
    base_stab = stab_err;
    foreach (cmd_q[i]) send_byte(cmd_q[i]);
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (got_tx.size() - base_tx >= exp_n && !busy && !tx_valid && !bus.wb_cyc_o) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " tx count"}, 32'(got_tx.size() - base_tx), 32'(exp_n));
    for (int i = 0; i < exp_n; i++)
      if (base_tx + i < got_tx.size())
        check($sformatf("%s tx byte %0d", tag, i), 32'(got_tx[base_tx + i]),
              32'(exp_bytes[31 - 8*i -: 8]));
    check({tag, " bus cycles"}, 32'(txn_cnt - base_txn), 32'd1);
    check({tag, " adr"}, m_adr, adr);
    check({tag, " we"}, 32'(m_we), 32'(wr));
    check({tag, " sel"}, 32'(m_sel), 32'hF);
    if (wr) check({tag, " dat"}, m_dat, dat);
    check({tag, " stable"}, 32'(stab_err - base_stab), 32'd0);
  endtask

  typedef struct {
    bit          has_junk;
    logic [7:0]  junk;
    bit          wr;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdata;
    bit          err;
    int          delay;
    int          exp_n;
    logic [31:0] exp_bytes;
  } vec_t;

  vec_t vt[6];

  initial begin
    int          n, hi, held, base_tx;
    logic [31:0] eb;
    bit          found;

    vt[0] = '{1'b0, 8'h00, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0, 3, 1, 32'h2E00_0000};
    vt[1] = '{1'b0, 8'h00, 1'b0, 32'h0000_7000, 32'h0,          32'h1234_5678, 1'b0, 1, 4, 32'h1234_5678};
    vt[2] = '{1'b1, 8'h41, 1'b0, 32'h0000_0004, 32'h0,          32'hA5A5_0F0F, 1'b0, 2, 4, 32'hA5A5_0F0F};
    vt[3] = '{1'b0, 8'h00, 1'b1, 32'h0000_0080, 32'h1111_2222, 32'h0,          1'b1, 2, 1, 32'h2100_0000};
    vt[4] = '{1'b0, 8'h00, 1'b0, 32'h8000_0000, 32'h0,          32'h5555_AAAA, 1'b1, 0, 1, 32'h2100_0000};
    vt[5] = '{1'b0, 8'h00, 1'b1, 32'h0000_0013, 32'h0000_0000, 32'h0,          1'b0, 0, 1, 32'h2E00_0000};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst cyc", 32'(bus.wb_cyc_o), 32'd0);
    check("rst stb", 32'(bus.wb_stb_o), 32'd0);
    check("rst sel", 32'(bus.wb_sel_o), 32'd0);
    check("rst we", 32'(bus.wb_we_o), 32'd0);
    check("rst adr", bus.wb_adr_o, 32'd0);
    check("rst dat", bus.wb_dat_o, 32'd0);
    check("rst tx_valid", 32'(tx_valid), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      slv_delay = vt[i].delay;
      slv_err   = vt[i].err;
      slv_rdata = vt[i].rdata;
      build_cmd(vt[i].wr, vt[i].adr, vt[i].dat, vt[i].has_junk, vt[i].junk);
      run_cmd($sformatf("vec%0d", i), vt[i].exp_n, vt[i].exp_bytes, vt[i].wr, vt[i].adr, vt[i].dat);
    end

    // Error response held under backpressure; a command byte arriving meanwhile is dropped.
    ready_mode = 1;
    slv_err    = 1'b1;
    slv_delay  = 1;
    base_tx    = got_tx.size();
    build_cmd(1'b1, 32'h0000_0200, 32'h0BAD_F00D, 1'b0, 8'h00);
    foreach (cmd_q[i]) send_byte(cmd_q[i]);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_valid) begin found = 1'b1; break; end
    end
    check("hold tx_valid rise", 32'(found), 32'd1);
    held = 0;
    send_byte(8'h52);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tx_valid && tx_data == 8'h21) held++;
    end
    check("hold cycles", 32'(held), 32'd10);
    ready_mode = 0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) begin found = 1'b1; break; end
    end
    check("hold release idle", 32'(found), 32'd1);
    check("hold tx count", 32'(got_tx.size() - base_tx), 32'd1);
    if (got_tx.size() > base_tx) check("hold tx byte", 32'(got_tx[base_tx]), 32'h21);
    repeat (10) @(negedge clk);
    check("dropped rx no busy", 32'(busy), 32'd0);
    check("dropped rx no cyc", 32'(bus.wb_cyc_o), 32'd0);

    // Reset while the bus cycle is outstanding.
    slv_err   = 1'b0;
    slv_noack = 1'b1;
    build_cmd(1'b0, 32'h0000_0020, 32'h0, 1'b0, 8'h00);
    foreach (cmd_q[i]) send_byte(cmd_q[i]);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.wb_cyc_o) begin found = 1'b1; break; end
    end
    check("rst-bus cyc seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst-bus cyc", 32'(bus.wb_cyc_o), 32'd0);
    check("rst-bus stb", 32'(bus.wb_stb_o), 32'd0);
    check("rst-bus tx_valid", 32'(tx_valid), 32'd0);
    check("rst-bus busy", 32'(busy), 32'd0);
    reset     = 1'b0;
    slv_noack = 1'b0;
    slv_delay = 2;
    build_cmd(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1'b0, 8'h00);
    run_cmd("after-rst", 1, 32'h2E00_0000, 1'b1, 32'h0000_0100, 32'hCAFE_F00D);

    // No acknowledge at all: timeout build aborts, default build waits.
    slv_noack = 1'b1;
    base_tx   = got_tx.size();
    build_cmd(1'b1, 32'h0000_0044, 32'h0000_0001, 1'b0, 8'h00);
    foreach (cmd_q[i]) send_byte(cmd_q[i]);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.wb_cyc_o) begin found = 1'b1; break; end
    end
    check("noack cyc seen", 32'(found), 32'd1);
    hi = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.wb_cyc_o) hi++;
      else break;
    end
`ifdef WB_DBG_TIMEOUT_EN
    check("timeout cyc length", 32'(hi), 32'(TMO));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("timeout tx count", 32'(got_tx.size() - base_tx), 32'd1);
    if (got_tx.size() > base_tx) check("timeout tx byte", 32'(got_tx[base_tx]), 32'h21);
`else
    check("no-timeout cyc held", 32'(hi), 32'd101);
    check("no-timeout no tx", 32'(got_tx.size() - base_tx), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`endif
    slv_noack = 1'b0;

    // Randomized commands with random backpressure, junk prefixes and slave errors.
    ready_mode = 2;
    for (int i = 0; i < 24; i++) begin
      bit          wr, err, hj;
      logic [31:0] adr, dat, rdata;
      logic [7:0]  junk;
      wr    = 1'($urandom_range(0, 1));
      err   = ($urandom_range(0, 3) == 0);
      hj    = ($urandom_range(0, 3) == 0);
      adr   = $urandom;
      dat   = $urandom;
      rdata = $urandom;
      junk  = 8'($urandom_range(0, 255));
      if (junk == 8'h57 || junk == 8'h52) junk = 8'h00;
      slv_delay = $urandom_range(0, 5);
      slv_err   = err;
      slv_rdata = rdata;
      model_rsp(wr, err, rdata, n, eb);
      build_cmd(wr, adr, dat, hj, junk);
      run_cmd($sformatf("rnd%0d", i), n, eb, wr, adr, dat);
    end
    ready_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
